// File: rtl/ram_dual_port_param_pkg.sv
// ram_pkg: shared definitions for the dual-port RAM.
//   state_t      - initialisation FSM states (CLEAR while zero-filling, READY after)
//   RD_LAT_MIN/MAX - supported read-latency range
//   BYTE_W       - width of one byte-enable lane
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int BYTE_W     = 8;

endpackage

// File: rtl/ram_dual_port_param_if.sv
// ram_dual_port_param_if: user-side port bundle of the dual-port RAM.
//   we/write_addr/data/be   - write port (byte-enabled)
//   re/read_addr            - read port
//   q/q_valid               - read result and its qualifier
//   init_done               - memory zero-fill finished, ports live
// master drives requests (bench/user), slave is the RAM.
interface ram_dual_port_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);

  logic                  we;
  logic [ADDR_W-1:0]     write_addr;
  logic [DATA_W-1:0]     data;
  logic [DATA_W/8-1:0]   be;
  logic                  re;
  logic [ADDR_W-1:0]     read_addr;
  logic [DATA_W-1:0]     q;
  logic                  q_valid;
  logic                  init_done;

  modport master (
    output we, write_addr, data, be, re, read_addr,
    input  q, q_valid, init_done
  );

  modport slave (
    input  we, write_addr, data, be, re, read_addr,
    output q, q_valid, init_done
  );

endinterface

// File: rtl/ram_dual_port_param_core.sv
// ram_dp_core: storage array with byte-lane write and asynchronous read.
//   clk     - write clock
//   we      - write strobe (already qualified by the top level)
//   waddr   - write address
//   wdata   - write data
//   be      - byte-lane enables, bit i gates wdata[8i+7:8i]
//   raddr   - read address
//   rdata   - current contents at raddr (pre-write value on a same-cycle write)
// The array has no reset; the top-level FSM zero-fills it after reset.
module ram_dp_core
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int NUM_LANES = DATA_W / BYTE_W;
  localparam int DEPTH     = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Byte-lane write: only enabled lanes are updated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we && be[i]) begin
        mem_r[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ram_dual_port_param.sv
// ram_dual_port_param: simple dual-port RAM with zero-fill after reset.
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   bus        - slave side of ram_dual_port_param_if (write, read, q, q_valid, init_done)
// Parameters: DATA_W (multiple of 8), ADDR_W (depth 2**ADDR_W),
//             RD_LAT (1 or 2), WR_FIRST (1 = new data on collision, 0 = old data).
module ram_dual_port_param
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_dual_port_param_if.slave  bus
);

  localparam int                NUM_LANES = DATA_W / BYTE_W;
  localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t                  state_r;
  state_t                  state_next_s;
  logic [ADDR_W-1:0]       clr_cnt_r;
  logic                    init_done_r;

  logic                    wr_acc_s;
  logic                    rd_acc_s;
  logic                    collide_s;
  logic                    core_we_s;
  logic [ADDR_W-1:0]       core_waddr_s;
  logic [DATA_W-1:0]       core_wdata_s;
  logic [NUM_LANES-1:0]    core_be_s;
  logic [DATA_W-1:0]       core_rdata_s;
  logic [DATA_W-1:0]       merged_s;
  logic [DATA_W-1:0]       rd_word_s;

  logic                    v1_r;
  logic [DATA_W-1:0]       d1_r;

  // FSM next-state: walk the clear counter to the last address, then stay READY.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_cnt_r == CNT_LAST) begin
          state_next_s = READY;
        end else begin
          state_next_s = CLEAR;
        end
      end
      READY:   state_next_s = READY;
      default: state_next_s = CLEAR;
    endcase
  end

  // FSM state, clear counter and registered init_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= CLEAR;
      clr_cnt_r   <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      init_done_r <= (state_next_s == READY);
      if (state_r == CLEAR) begin
        clr_cnt_r <= clr_cnt_r + CNT_ONE;
      end else begin
        clr_cnt_r <= {ADDR_W{1'b0}};
      end
    end
  end

  // Port qualification and write-port mux: the clear sequence owns the
  // write port until READY, and user requests are dropped meanwhile.
  always_comb begin
    wr_acc_s     = 1'b0;
    rd_acc_s     = 1'b0;
    core_we_s    = 1'b0;
    core_waddr_s = {ADDR_W{1'b0}};
    core_wdata_s = {DATA_W{1'b0}};
    core_be_s    = {NUM_LANES{1'b0}};
    if (state_r == READY) begin
      wr_acc_s     = bus.we;
      rd_acc_s     = bus.re;
      core_we_s    = bus.we;
      core_waddr_s = bus.write_addr;
      core_wdata_s = bus.data;
      core_be_s    = bus.be;
    end else begin
      core_we_s    = 1'b1;
      core_waddr_s = clr_cnt_r;
      core_wdata_s = {DATA_W{1'b0}};
      core_be_s    = {NUM_LANES{1'b1}};
    end
  end

  // Collision handling: the core returns the pre-write word; in write-first
  // mode the enabled lanes of the incoming write are merged on top of it.
  always_comb begin
    merged_s  = core_rdata_s;
    collide_s = wr_acc_s && rd_acc_s && (bus.write_addr == bus.read_addr);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.be[i]) begin
        merged_s[i*BYTE_W +: BYTE_W] = bus.data[i*BYTE_W +: BYTE_W];
      end else begin
        merged_s[i*BYTE_W +: BYTE_W] = core_rdata_s[i*BYTE_W +: BYTE_W];
      end
    end
    if ((WR_FIRST != 0) && collide_s) begin
      rd_word_s = merged_s;
    end else begin
      rd_word_s = core_rdata_s;
    end
  end

  ram_dp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we_s),
    .waddr (core_waddr_s),
    .wdata (core_wdata_s),
    .be    (core_be_s),
    .raddr (bus.read_addr),
    .rdata (core_rdata_s)
  );

  // First read stage: capture the word on an accepted read, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r <= 1'b0;
      d1_r <= {DATA_W{1'b0}};
    end else begin
      v1_r <= rd_acc_s;
      if (rd_acc_s) begin
        d1_r <= rd_word_s;
      end
    end
  end

  generate
    if (RD_LAT == RD_LAT_MIN) begin : g_lat1
      assign bus.q       = d1_r;
      assign bus.q_valid = v1_r;
    end else begin : g_lat2
      logic              v2_r;
      logic [DATA_W-1:0] d2_r;

      // Second read stage: fully pipelined, q holds across empty slots.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2_r <= 1'b0;
          d2_r <= {DATA_W{1'b0}};
        end else begin
          v2_r <= v1_r;
          if (v1_r) begin
            d2_r <= d1_r;
          end
        end
      end

      assign bus.q       = d2_r;
      assign bus.q_valid = v2_r;
    end
  endgenerate

  assign bus.init_done = init_done_r;

endmodule

// File: doc/ram_dual_port_param.md
RAM_DUAL_PORT_PARAM -- requirements
Module: ram_dual_port_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data width in bits; legal values are multiples of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning address width; depth is 2**ADDR_W words.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning read latency in cycles; legal values are 1 and 2.
REQ-004 The block SHALL have parameter WR_FIRST, default 0; 1 means write-first collision behaviour and 0 means read-first (old data).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port we, input, 1 bit: write enable.
REQ-008 The block SHALL have port write_addr, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port data, input, DATA_W bits: write data.
REQ-010 The block SHALL have port be, input, DATA_W/8 bits: byte enables; bit i gates data[8i+7:8i].
REQ-011 The block SHALL have port re, input, 1 bit: read enable.
REQ-012 The block SHALL have port read_addr, input, ADDR_W bits: read address.
REQ-013 The block SHALL have port q, output, DATA_W bits: read data.
REQ-014 The block SHALL have port q_valid, output, 1 bit: q holds the result of an accepted read.
REQ-015 The block SHALL have port init_done, output, 1 bit: memory clear is complete and ports are accepted.

Function
REQ-016 The block SHALL have a two-state FSM: CLEAR (entered on reset) and READY.
REQ-017 In CLEAR, an ADDR_W-bit counter SHALL write 0 to one address per cycle, from 0 up to 2**ADDR_W-1.
REQ-018 The FSM SHALL move CLEAR->READY in the cycle after address 2**ADDR_W-1 is cleared; init_done SHALL be 1 in READY and 0 in CLEAR.
REQ-019 In CLEAR, we and re SHALL be ignored: no user write takes effect and q_valid stays 0.
REQ-020 In READY with we=1, each byte lane with be[i]=1 SHALL be written at write_addr on the clock edge; lanes with be[i]=0 SHALL keep their contents.
REQ-021 In READY with re=1, mem[read_addr] SHALL appear on q with q_valid=1 exactly RD_LAT cycles after the accepting edge.
REQ-022 With RD_LAT=2, the read SHALL be fully pipelined: back-to-back reads give back-to-back valid results.
REQ-023 When re=0 at the launch cycle, q SHALL hold its previous value and q_valid SHALL be 0 for that result slot.
REQ-024 On collision (we=1, re=1, write_addr==read_addr in the same cycle), WR_FIRST=1 SHALL return the byte-merged new word and WR_FIRST=0 SHALL return the pre-write word.
REQ-025 A write SHALL be visible to any read launched in a later cycle.
REQ-026 Addresses SHALL cover the full 0..2**ADDR_W-1 range with no wrap or aliasing.

Reset
REQ-027 Asserting rst SHALL immediately set q=0, q_valid=0, init_done=0, clear all pipeline valid bits, and put the FSM in CLEAR with the counter at 0.
REQ-028 Reset asserted mid-clear or mid-operation SHALL restart the full clear sequence; memory contents are not guaranteed until init_done=1.
REQ-029 The memory array itself SHALL NOT be reset asynchronously; only the FSM clears it.

Structure
REQ-030 A shared package ram_pkg SHALL hold the FSM state enum (CLEAR, READY) and the RD_LAT range constants.
REQ-031 The storage array plus byte-lane write logic SHALL be one sub-module, ram_dp_core; FSM, collision logic and read pipeline SHALL live in the top level.

Verification
REQ-032 Scenario, reset then idle: release rst -> init_done rises exactly 64 cycles later (defaults); a read of each of addresses 0x00..0x3F returns 0x00.
REQ-033 Scenario, basic write/read: write 0xAA@0x00 and 0x55@0x3F, then read both -> q=0xAA then 0x55, each with q_valid RD_LAT cycles after the read.
REQ-034 Scenario, byte enables (DATA_W=16): write 0x1234@0x05 with be=11, then 0xABCD@0x05 with be=01 -> read returns 0x12CD.
REQ-035 Scenario, collision: mem[0x0A]=0x11, then we=1, re=1, both addresses 0x0A, data=0xFF -> q=0xFF if WR_FIRST=1, q=0x11 if WR_FIRST=0; a read in the next cycle returns 0xFF in both modes.
REQ-036 Scenario, RD_LAT=2 streaming: reads of 0x01, 0x02, 0x03 on consecutive cycles -> q_valid high for 3 consecutive cycles starting 2 cycles later, with correct data in order.
REQ-037 Scenario, reset mid-operation: assert rst during a read burst -> q_valid drops immediately, init_done drops, and after release earlier data (0xAA@0x00) reads back 0x00.
